// File: rtl/rgb_arbiter.sv
// rgb_arbiter: round-robin sharing of one registered rgb colour converter between N_REQ requesters.
module rgb_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int CONV_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   req_colour,
  output logic [N_REQ-1:0]     gnt,
  output logic [2:0]           conv_colour,
  output logic                 conv_enable,
  input  logic [23:0]          conv_rgb,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [23:0]          rsp_rgb,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ID_W-1:0] win, win_n, last, last_n, pick;
  logic found;
  logic [N_REQ-1:0] gnt_n;
  logic [2:0] colour_n;
  logic en_n, valid_n;
  logic [ID_W-1:0] id_n;
  logic [23:0] rgb_n;
  assign busy = state != IDLE;
  // first asserted request at or after last+1, wrapping modulo N_REQ
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++)
      if (!found && req[(int'(last) + i) % N_REQ]) begin
        found = 1'b1;
        pick = ID_W'((int'(last) + i) % N_REQ);
      end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    win_n = win;
    last_n = last;
    gnt_n = '0;
    colour_n = conv_colour;
    en_n = conv_enable;
    valid_n = 1'b0;
    id_n = rsp_id;
    rgb_n = rsp_rgb;
    case (state)
      IDLE: begin
        en_n = |req;
        if (|req) begin
          state_n = WAIT;
          cnt_n = 4'(CONV_LATENCY);
          win_n = pick;
          gnt_n = N_REQ'(1) << pick;
          colour_n = req_colour[3*int'(pick) +: 3];
        end
      end
      WAIT: begin
        cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = RESP;
          rgb_n = conv_rgb;
          id_n = win;
          valid_n = 1'b1;
          en_n = 1'b0;
          last_n = win;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      win <= '0;
      last <= ID_W'(N_REQ - 1);
      gnt <= '0;
      conv_colour <= '0;
      conv_enable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_rgb <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      win <= win_n;
      last <= last_n;
      gnt <= gnt_n;
      conv_colour <= colour_n;
      conv_enable <= en_n;
      rsp_valid <= valid_n;
      rsp_id <= id_n;
      rsp_rgb <= rgb_n;
    end
  end
endmodule

// File: tb/tb_rgb_arbiter.sv
// tb_rgb_arbiter: directed checks of rgb_arbiter with a behavioural one-cycle colour converter.
module tb_rgb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [11:0] req_colour;
  logic [3:0] gnt;
  logic [2:0] conv_colour;
  logic conv_enable;
  logic [23:0] conv_rgb;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [23:0] rsp_rgb;
  logic busy;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [23:0] exp_rgb [5] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h0000FF};
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    if (rst) conv_rgb <= '0;
    else if (conv_enable) conv_rgb <= {{8{conv_colour[2]}}, {8{conv_colour[1]}}, {8{conv_colour[0]}}};
  rgb_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_colour(req_colour), .gnt(gnt),
    .conv_colour(conv_colour), .conv_enable(conv_enable), .conv_rgb(conv_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb), .busy(busy)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    req_colour = {3'd7, 3'd4, 3'd2, 3'd1};
    tick(2);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (conv_enable !== 1'b0) begin errors++; $display("FAIL reset_conv_enable got=%b exp=0", conv_enable); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_rgb !== 24'h0) begin errors++; $display("FAIL reset_rsp_rgb got=%h exp=000000", rsp_rgb); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    req = 4'b0;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_tail_busy got=%b exp=0", busy); end
  endtask
  task automatic test_single;
    req = 4'b0100;
    req_colour = {3'd0, 3'b101, 3'd0, 3'd0};
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (conv_colour !== 3'd5) begin errors++; $display("FAIL single_conv_colour got=%0d exp=5", conv_colour); end
    checks++; if (conv_enable !== 1'b1) begin errors++; $display("FAIL single_conv_enable got=%b exp=1", conv_enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    req = 4'b0;
    tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
    checks++; if (rsp_rgb !== 24'hFF00FF) begin errors++; $display("FAIL single_rsp_rgb got=%h exp=ff00ff", rsp_rgb); end
    checks++; if (conv_enable !== 1'b0) begin errors++; $display("FAIL single_enable_off got=%b exp=0", conv_enable); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (rsp_rgb !== 24'hFF00FF) begin errors++; $display("FAIL single_rgb_hold got=%h exp=ff00ff", rsp_rgb); end
  endtask
  task automatic test_full_load;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    req_colour = {3'd7, 3'd4, 3'd2, 3'd1};
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++; if (gnt !== 4'(1) << exp_id[t]) begin errors++; $display("FAIL full_gnt[%0d] got=%b exp=%b", t, gnt, 4'(1) << exp_id[t]); end
      tick(2);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d] got=%b exp=1", t, rsp_valid); end
      checks++; if (rsp_id !== exp_id[t]) begin errors++; $display("FAIL full_id[%0d] got=%0d exp=%0d", t, rsp_id, exp_id[t]); end
      checks++; if (rsp_rgb !== exp_rgb[t]) begin errors++; $display("FAIL full_rgb[%0d] got=%h exp=%h", t, rsp_rgb, exp_rgb[t]); end
      tick();
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL full_no_gnt_in_resp[%0d] got=%b exp=0000", t, gnt); end
    end
    req = 4'b0;
  endtask
  task automatic test_fairness;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fair_first got=%b exp=0010", gnt); end
    req = 4'b0;
    tick(3);
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL fair_second got=%b exp=1000", gnt); end
    req = 4'b0010;
    tick(3);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL fair_third got=%b exp=0010", gnt); end
    req = 4'b0;
    tick(3);
  endtask
  task automatic test_reset_wait;
    req_colour = {3'd0, 3'd6, 3'd3, 3'd1};
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rwait_gnt got=%b exp=0100", gnt); end
    req = 4'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rwait_busy got=%b exp=0", busy); end
    checks++; if (conv_enable !== 1'b0) begin errors++; $display("FAIL rwait_enable got=%b exp=0", conv_enable); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rwait_no_valid[%0d] got=%b exp=0", k, rsp_valid); end
    end
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rwait_regrant got=%b exp=0001", gnt); end
    req = 4'b0;
    tick(3);
  endtask
  task automatic test_late_arrival;
    req = 4'b0100;
    tick();
    req = 4'b0;
    tick(2);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== 24'hFFFF00) begin errors++; $display("FAIL late_prev_rsp got=%b/%0d/%h exp=1/2/ffff00", rsp_valid, rsp_id, rsp_rgb); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL late_gnt_in_resp got=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL late_gnt got=%b exp=0010", gnt); end
    req = 4'b0;
    tick();
    checks++; if (rsp_id !== 2'd2 || rsp_rgb !== 24'hFFFF00) begin errors++; $display("FAIL late_hold got=%0d/%h exp=2/ffff00", rsp_id, rsp_rgb); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rgb !== 24'h00FFFF) begin errors++; $display("FAIL late_rsp got=%b/%0d/%h exp=1/1/00ffff", rsp_valid, rsp_id, rsp_rgb); end
    tick();
  endtask
  task automatic test_colour_zero;
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL zero_gnt got=%b exp=1000", gnt); end
    req = 4'b0;
    tick(2);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rgb !== 24'h000000) begin errors++; $display("FAIL zero_rsp got=%b/%0d/%h exp=1/3/000000", rsp_valid, rsp_id, rsp_rgb); end
    tick();
  endtask
  initial begin
    rst = 1'b1;
    req = 4'b0;
    req_colour = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full_load();
    test_fairness();
    test_reset_wait();
    test_late_arrival();
    test_colour_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_arbiter.md
Name: rgb_arbiter

Overview:
- Round-robin arbiter that shares one RGB colour converter (3-bit colour code in, 24-bit rgb out, registered, gated by enable) between N_REQ requesters.
- Each requester presents a colour code. The arbiter grants one requester, drives the converter, waits out the converter latency, then returns the captured rgb word tagged with the requester id.
- Sits between display/pattern-generator clients and the converter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ.
- CONV_LATENCY, 1, clock edges from conv_enable/conv_colour valid until conv_rgb is valid (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester, level.
- req_colour  input  3*N_REQ  colour code of requester i at bits [3i+2:3i].
- gnt  output  N_REQ  one-hot grant, registered, high exactly one cycle per transaction.
- conv_colour  output  3  colour code to converter.
- conv_enable  output  1  converter enable.
- conv_rgb  input  24  converter result.
- rsp_valid  output  1  one-cycle pulse, response valid.
- rsp_id  output  ID_W  index of the served requester; held until the next response.
- rsp_rgb  output  24  captured rgb; held until the next response.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE, the wait counter to 0, and the priority pointer so that requester 0 has highest priority.
  - All outputs become 0 on the following cycle.
  - Reset dominates every other event. A transaction in flight is abandoned and produces no rsp_valid.
- States: IDLE, WAIT, RESP.
- IDLE, at edge E0 with req != 0:
  - Select the first asserted req searching from (last_granted+1) mod N_REQ upward, with wrap.
  - Register gnt = onehot(winner), conv_colour = req_colour[winner], conv_enable = 1, wait counter = CONV_LATENCY.
  - Record the winner and go to WAIT.
  - If req == 0, stay in IDLE with conv_enable = 0; the converter then holds its last rgb.
- WAIT:
  - gnt goes to 0 at the first WAIT edge. conv_colour and conv_enable are held.
  - The counter decrements each edge while nonzero.
  - At the edge where the counter == 0: rsp_rgb <= conv_rgb, rsp_id <= winner, rsp_valid <= 1, conv_enable <= 0, last_granted <= winner, go to RESP.
- RESP: rsp_valid <= 0 and go to IDLE. No arbitration happens in RESP.
- Timing:
  - rsp_valid is high in the cycle after edge E0+CONV_LATENCY+1.
  - Minimum spacing between grants is CONV_LATENCY+3 cycles.
- Handshake:
  - A requester holds req and req_colour stable until it sees its gnt bit. The colour is captured at the grant edge.
  - A requester that keeps req high after its gnt is treated as issuing a new request and competes again.
  - Changes to req or req_colour during WAIT/RESP have no effect on the transaction in flight.
  - Dropping req before grant withdraws the request with no side effects.
- Pointer wraps modulo N_REQ. Indices >= N_REQ are never granted.
- Colour 0 is legal and expected to return 24'h000000.
- Converter mapping relied on by the bench: colour[0] -> rgb[7:0] all ones, colour[1] -> rgb[15:8], colour[2] -> rgb[23:16].

Test Plan:
- Reset: rst high for 2 cycles with req = 4'b1111 -> gnt, conv_enable, rsp_valid, busy, rsp_rgb all 0; after release, first grant is requester 0.
- Single request: req = 4'b0100, colour 3'b101 at E0 -> gnt = 4'b0100 for one cycle; conv_colour = 5; conv_enable = 1; rsp_valid one cycle after E0+2 with rsp_id = 2, rsp_rgb = 24'hFF00FF; busy low again 4 cycles after E0.
- Full load: all req held, colours 1, 2, 4, 7 -> grant order 0,1,2,3,0; rsp_rgb 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF; grants exactly 4 cycles apart (CONV_LATENCY = 1).
- Fairness: requester 1 served, then req = 4'b1010 -> next grant is 3, then 1.
- Reset during WAIT: rst pulsed one cycle after the grant to requester 2 -> no rsp_valid; a subsequent req = 4'b0101 grants 0 first.
- Late arrival: req[1] rises during RESP -> not granted until the first IDLE edge; rsp_id/rsp_rgb hold previous values until the new rsp_valid.
